// File: rtl/alu_uart_pkg.sv
// Shared definitions for the ALU/UART command and response path.
// Covers the response FSM states, frame lengths and the byte selection helper.
package alu_uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_HI,
    ST_WAIT_LO
  } tx_state_e;

  localparam int unsigned RESP_BYTES_W_FLAGS  = 3;
  localparam int unsigned RESP_BYTES_NO_FLAGS = 2;
  localparam int unsigned FLAGS_PAD_W         = 3;

  typedef struct packed {
    logic [15:0] result;
    logic [4:0]  flags;
  } resp_t;

  // Response frame order: result low byte, result high byte, padded flags.
  function automatic logic [7:0] resp_byte(input resp_t r, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = r.result[7:0];
      2'd1:    b = r.result[15:8];
      default: b = {{FLAGS_PAD_W{1'b0}}, r.flags};
    endcase
    return b;
  endfunction

endpackage

// File: rtl/alu_result_tx.sv
// Serialises captured ALU result/flags into a 2- or 3-byte response frame
// over the uart_basic tx_start/tx_data/tx_busy handshake, with a one-deep request slot.
module alu_result_tx
  import alu_uart_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter bit SEND_FLAGS = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             send_result,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [4:0]       alu_flags,
  input  logic             tx_busy,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  output logic             busy,
  output logic             overrun
);

  localparam logic [1:0] LAST_IDX = SEND_FLAGS ? 2'(RESP_BYTES_W_FLAGS - 1)
                                               : 2'(RESP_BYTES_NO_FLAGS - 1);

  tx_state_e  state, state_n;
  logic [1:0] idx, idx_n;
  resp_t      shadow, pend, incoming;
  logic       pend_valid;

  logic cap_active, cap_pend, pop_pend, drop, fire;

  assign incoming = '{result: alu_out, flags: alu_flags};
  assign busy     = (state != ST_IDLE) || pend_valid;

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    cap_active = 1'b0;
    cap_pend   = 1'b0;
    pop_pend   = 1'b0;
    drop       = 1'b0;
    fire       = 1'b0;

    case (state)
      ST_IDLE: begin
        // A waiting slot is older than a fresh request, so it goes first and
        // the fresh request refills the slot being vacated.
        if (pend_valid) begin
          pop_pend = 1'b1;
          cap_pend = send_result;
          idx_n    = 2'd0;
          state_n  = ST_START;
        end else if (send_result) begin
          cap_active = 1'b1;
          idx_n      = 2'd0;
          state_n    = ST_START;
        end
      end
      ST_START: begin
        if (!tx_busy) begin
          fire    = 1'b1;
          state_n = ST_WAIT_HI;
        end
      end
      ST_WAIT_HI: begin
        if (tx_busy) state_n = ST_WAIT_LO;
      end
      ST_WAIT_LO: begin
        if (!tx_busy) begin
          if (idx == LAST_IDX) begin
            state_n = ST_IDLE;
          end else begin
            idx_n   = idx + 2'd1;
            state_n = ST_START;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (state != ST_IDLE && send_result) begin
      if (pend_valid) drop     = 1'b1;
      else            cap_pend = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      idx        <= 2'd0;
      shadow     <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
      overrun    <= 1'b0;
      tx_start   <= 1'b0;
      tx_data    <= 8'h00;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      tx_start <= fire;
      if (fire)       tx_data <= resp_byte(shadow, idx);
      if (cap_active) shadow  <= incoming;
      else if (pop_pend) shadow <= pend;
      if (cap_pend) begin
        pend       <= incoming;
        pend_valid <= 1'b1;
      end else if (pop_pend) begin
        pend_valid <= 1'b0;
      end
      if (drop) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_result_tx.sv
// Directed bench for alu_result_tx: one instance with the flags byte, one without,
// each fed by a simple uart_basic busy model.
module tb_alu_result_tx;

  localparam int unsigned BYTE_CYC = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        send_result = 1'b0;
  logic [15:0] alu_out = 16'h0000;
  logic [4:0]  alu_flags = 5'h00;
  logic        force_busy = 1'b0;

  logic        ub1 = 1'b0, ub0 = 1'b0;
  int unsigned uc1 = 0, uc0 = 0;
  logic        tx_busy1, tx_busy0;
  logic        tx_start1, tx_start0, busy1, busy0, overrun1, overrun0;
  logic [7:0]  tx_data1, tx_data0;

  assign tx_busy1 = ub1 | force_busy;
  assign tx_busy0 = ub0 | force_busy;

  int checks = 0;
  int errors = 0;
  int viol   = 0;
  logic [7:0] q1[$];
  logic [7:0] q0[$];
  logic ps1 = 1'b0, ps0 = 1'b0;

  alu_result_tx #(.WIDTH(16), .SEND_FLAGS(1'b1)) dut1 (
    .clk(clk), .reset(reset), .send_result(send_result), .alu_out(alu_out),
    .alu_flags(alu_flags), .tx_busy(tx_busy1), .tx_start(tx_start1),
    .tx_data(tx_data1), .busy(busy1), .overrun(overrun1)
  );

  alu_result_tx #(.WIDTH(16), .SEND_FLAGS(1'b0)) dut0 (
    .clk(clk), .reset(reset), .send_result(send_result), .alu_out(alu_out),
    .alu_flags(alu_flags), .tx_busy(tx_busy0), .tx_start(tx_start0),
    .tx_data(tx_data0), .busy(busy0), .overrun(overrun0)
  );

  // uart_basic stand-in: busy for BYTE_CYC cycles after each accepted tx_start.
  always @(posedge clk) begin
    if (uc1 != 0) begin
      uc1 <= uc1 - 1;
      if (uc1 == 1) ub1 <= 1'b0;
    end else if (tx_start1) begin
      ub1 <= 1'b1;
      uc1 <= BYTE_CYC;
    end
    if (uc0 != 0) begin
      uc0 <= uc0 - 1;
      if (uc0 == 1) ub0 <= 1'b0;
    end else if (tx_start0) begin
      ub0 <= 1'b1;
      uc0 <= BYTE_CYC;
    end
  end

  always @(negedge clk) begin
    if (tx_start1) begin
      q1.push_back(tx_data1);
      if (ps1 || tx_busy1) viol++;
    end
    if (tx_start0) begin
      q0.push_back(tx_data0);
      if (ps0 || tx_busy0) viol++;
    end
    ps1 = tx_start1;
    ps0 = tx_start0;
  end

  task automatic send(input logic [15:0] v, input logic [4:0] f);
    @(negedge clk);
    send_result = 1'b1;
    alu_out     = v;
    alu_flags   = f;
    @(negedge clk);
    send_result = 1'b0;
    alu_out     = 16'hDEAD;
    alu_flags   = 5'h1F;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!busy1 && !busy0 && !tx_busy1 && !tx_busy0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (tx_start1 !== 1'b0) begin errors++; $display("FAIL reset_tx_start got=%b exp=0", tx_start1); end
    checks++; if (tx_data1 !== 8'h00) begin errors++; $display("FAIL reset_tx_data got=%h exp=00", tx_data1); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy1); end
    checks++; if (overrun1 !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", overrun1); end
    checks++; if ({tx_start0, busy0, overrun0, tx_data0} !== 11'h000) begin errors++; $display("FAIL reset_dut0 got=%h exp=000", {tx_start0, busy0, overrun0, tx_data0}); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single;
    bit ok;
    logic [7:0] e1[$];
    logic [7:0] e0[$];
    q1.delete(); q0.delete();
    send(16'h12F4, 5'b10011);
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL single_busy_at_capture got=%b exp=1", busy1); end
    checks++; if (tx_start1 !== 1'b0) begin errors++; $display("FAIL single_start_early got=%b exp=0", tx_start1); end
    @(negedge clk);
    checks++; if (tx_start1 !== 1'b1) begin errors++; $display("FAIL single_start_latency got=%b exp=1", tx_start1); end
    checks++; if (tx_data1 !== 8'hF4) begin errors++; $display("FAIL single_first_data got=%h exp=f4", tx_data1); end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout got=busy exp=idle"); end
    e1 = '{8'hF4, 8'h12, 8'h13};
    e0 = '{8'hF4, 8'h12};
    checks++; if (q1.size() != e1.size()) begin errors++; $display("FAIL single_count got=%0d exp=%0d", q1.size(), e1.size()); end
    for (int i = 0; i < e1.size() && i < q1.size(); i++) begin
      checks++; if (q1[i] !== e1[i]) begin errors++; $display("FAIL single_byte%0d got=%h exp=%h", i, q1[i], e1[i]); end
    end
    checks++; if (q0.size() != e0.size()) begin errors++; $display("FAIL single_nf_count got=%0d exp=%0d", q0.size(), e0.size()); end
    checks++; if (overrun1 !== 1'b0) begin errors++; $display("FAIL single_overrun got=%b exp=0", overrun1); end
  endtask

  task automatic test_no_flags;
    bit ok;
    logic [7:0] e1[$];
    logic [7:0] e0[$];
    q1.delete(); q0.delete();
    send(16'hFFFF, 5'b11111);
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL noflags_timeout got=busy exp=idle"); end
    e0 = '{8'hFF, 8'hFF};
    e1 = '{8'hFF, 8'hFF, 8'h1F};
    checks++; if (q0.size() != e0.size()) begin errors++; $display("FAIL noflags_count got=%0d exp=%0d", q0.size(), e0.size()); end
    for (int i = 0; i < e0.size() && i < q0.size(); i++) begin
      checks++; if (q0[i] !== e0[i]) begin errors++; $display("FAIL noflags_byte%0d got=%h exp=%h", i, q0[i], e0[i]); end
    end
    checks++; if (q1.size() != e1.size() || q1[2] !== e1[2]) begin errors++; $display("FAIL flags_byte_all_ones got=%0d bytes exp=3 ending 1f", q1.size()); end
  endtask

  task automatic test_back_to_back;
    int gaps;
    bit done;
    logic [7:0] e1[$];
    logic [7:0] e0[$];
    q1.delete(); q0.delete();
    send(16'h0001, 5'h0A);
    repeat (3) @(negedge clk);
    send(16'h0002, 5'h15);
    gaps = 0;
    done = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (q1.size() < 6 && !busy1) gaps++;
      if (!busy1 && !busy0 && !tx_busy1 && !tx_busy0) begin
        done = 1'b1;
        break;
      end
    end
    checks++; if (!done) begin errors++; $display("FAIL b2b_timeout got=busy exp=idle"); end
    checks++; if (gaps != 0) begin errors++; $display("FAIL b2b_busy_gap got=%0d exp=0", gaps); end
    e1 = '{8'h01, 8'h00, 8'h0A, 8'h02, 8'h00, 8'h15};
    e0 = '{8'h01, 8'h00, 8'h02, 8'h00};
    checks++; if (q1.size() != e1.size()) begin errors++; $display("FAIL b2b_count got=%0d exp=%0d", q1.size(), e1.size()); end
    for (int i = 0; i < e1.size() && i < q1.size(); i++) begin
      checks++; if (q1[i] !== e1[i]) begin errors++; $display("FAIL b2b_byte%0d got=%h exp=%h", i, q1[i], e1[i]); end
    end
    checks++; if (q0.size() != e0.size()) begin errors++; $display("FAIL b2b_nf_count got=%0d exp=%0d", q0.size(), e0.size()); end
    for (int i = 0; i < e0.size() && i < q0.size(); i++) begin
      checks++; if (q0[i] !== e0[i]) begin errors++; $display("FAIL b2b_nf_byte%0d got=%h exp=%h", i, q0[i], e0[i]); end
    end
    checks++; if (overrun1 !== 1'b0) begin errors++; $display("FAIL b2b_overrun got=%b exp=0", overrun1); end
  endtask

  task automatic test_overrun;
    bit ok;
    logic [7:0] e1[$];
    q1.delete(); q0.delete();
    @(negedge clk);
    send_result = 1'b1; alu_out = 16'h3344; alu_flags = 5'h01;
    @(negedge clk);
    alu_out = 16'h5566; alu_flags = 5'h02;
    @(negedge clk);
    alu_out = 16'h7788; alu_flags = 5'h03;
    @(negedge clk);
    send_result = 1'b0; alu_out = 16'h0000; alu_flags = 5'h00;
    checks++; if (overrun1 !== 1'b1) begin errors++; $display("FAIL overrun_flag got=%b exp=1", overrun1); end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL overrun_timeout got=busy exp=idle"); end
    repeat (2 * BYTE_CYC) @(negedge clk);
    e1 = '{8'h44, 8'h33, 8'h01, 8'h66, 8'h55, 8'h02};
    checks++; if (q1.size() != e1.size()) begin errors++; $display("FAIL overrun_count got=%0d exp=%0d", q1.size(), e1.size()); end
    for (int i = 0; i < e1.size() && i < q1.size(); i++) begin
      checks++; if (q1[i] !== e1[i]) begin errors++; $display("FAIL overrun_byte%0d got=%h exp=%h", i, q1[i], e1[i]); end
    end
    checks++; if (overrun1 !== 1'b1 || overrun0 !== 1'b1) begin errors++; $display("FAIL overrun_sticky got=%b%b exp=11", overrun1, overrun0); end
  endtask

  task automatic test_busy_hold;
    bit ok;
    int early;
    logic [7:0] e1[$];
    q1.delete(); q0.delete();
    force_busy = 1'b1;
    send(16'h12F4, 5'b10011);
    early = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_start1 !== 1'b0) early++;
    end
    checks++; if (early != 0) begin errors++; $display("FAIL hold_start_while_busy got=%0d exp=0", early); end
    force_busy = 1'b0;
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL hold_timeout got=busy exp=idle"); end
    e1 = '{8'hF4, 8'h12, 8'h13};
    checks++; if (q1.size() != e1.size()) begin errors++; $display("FAIL hold_count got=%0d exp=%0d", q1.size(), e1.size()); end
    for (int i = 0; i < e1.size() && i < q1.size(); i++) begin
      checks++; if (q1[i] !== e1[i]) begin errors++; $display("FAIL hold_byte%0d got=%h exp=%h", i, q1[i], e1[i]); end
    end
  endtask

  task automatic test_midframe_reset;
    bit ok;
    bit seen;
    logic [7:0] e1[$];
    logic [7:0] e0[$];
    q1.delete(); q0.delete();
    send(16'h12F4, 5'b10011);
    seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (q1.size() == 2 && tx_busy1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL mreset_reach_byte1 got=%0d bytes exp=2", q1.size()); end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (tx_start1 !== 1'b0) begin errors++; $display("FAIL mreset_tx_start got=%b exp=0", tx_start1); end
    checks++; if (busy1 !== 1'b0 || busy0 !== 1'b0) begin errors++; $display("FAIL mreset_busy got=%b%b exp=00", busy1, busy0); end
    checks++; if (overrun1 !== 1'b0 || overrun0 !== 1'b0) begin errors++; $display("FAIL mreset_overrun got=%b%b exp=00", overrun1, overrun0); end
    reset = 1'b0;
    wait_idle(ok);
    checks++; if (q1.size() != 2) begin errors++; $display("FAIL mreset_abandon got=%0d exp=2", q1.size()); end
    q1.delete(); q0.delete();
    send(16'hABCD, 5'b00101);
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL mreset_timeout got=busy exp=idle"); end
    e1 = '{8'hCD, 8'hAB, 8'h05};
    e0 = '{8'hCD, 8'hAB};
    checks++; if (q1.size() != e1.size()) begin errors++; $display("FAIL mreset_count got=%0d exp=%0d", q1.size(), e1.size()); end
    for (int i = 0; i < e1.size() && i < q1.size(); i++) begin
      checks++; if (q1[i] !== e1[i]) begin errors++; $display("FAIL mreset_byte%0d got=%h exp=%h", i, q1[i], e1[i]); end
    end
    checks++; if (q0.size() != e0.size()) begin errors++; $display("FAIL mreset_nf_count got=%0d exp=%0d", q0.size(), e0.size()); end
    for (int i = 0; i < e0.size() && i < q0.size(); i++) begin
      checks++; if (q0[i] !== e0[i]) begin errors++; $display("FAIL mreset_nf_byte%0d got=%h exp=%h", i, q0[i], e0[i]); end
    end
  endtask

  task automatic test_protocol;
    checks++; if (viol != 0) begin errors++; $display("FAIL protocol_tx_start got=%0d violations exp=0", viol); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_no_flags();
    test_back_to_back();
    test_overrun();
    test_busy_hold();
    test_midframe_reset();
    test_protocol();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
